// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with an iterative multiply/divide unit.
//
// The ALU results are combinational on y from the live a/b/op inputs.
// MULT/MULTU/DIV/DIVU are launched by start. They run for WIDTH iteration
// cycles plus one sign-fix cycle and then write the architectural HI/LO.
// MTHI/MTLO write HI/LO one cycle after the start that launched them.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   a, b         operands (dividend/multiplicand, divisor/multiplier)
//   op           operation select; op[3]=0 ALU group, op[3]=1 MDU group
//   start        launches an MDU op in op (sampled on the rising edge)
//   y, zero      combinational result and its y==0 flag
//   busy         multiply/divide in progress
//   done         one-cycle pulse once HI/LO hold the new result
//   hi, lo       architectural HI/LO registers
//   div_by_zero  last completed divide had b=0; held until next accepted start
module alu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DZ,
    S_MT
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {remainder, dividend bits shifting into quotient}.
  // DZ/MT:    low half carries the captured a.
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;  // |a| for multiply, |b| for divide
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;      // negate product / quotient
  logic               rneg_q, rneg_d;    // negate remainder
  logic               mt_lo_q, mt_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               sgn_op;
  logic               accept;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // ALU datapath.
  always_comb begin
    y = '0;
    case (op)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a + b;
      4'b0011: y = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0100: y = a & ~b;
      4'b0101: y = a | ~b;
      4'b0110: y = a - b;
      4'b0111: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: y = hi_q;
      4'b1101: y = lo_q;
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

  // MULT/DIV are odd opcodes within 10xx.
  assign sgn_op = op[0];
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // MDU ops that start takes: 10xx (mult/div) and 111x (MT*); MF* (110x) is not one of them.
  assign accept = (state_q == S_IDLE) && start && op[3] && !(op[2] && !op[1]);

  assign add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign div_diff = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
  assign prod_neg = ~prod_q + 1'b1;
  assign quo_fix  = neg_q  ? (~prod_q[WIDTH-1:0] + 1'b1)       : prod_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1) : prod_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    mt_lo_d  = mt_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dbz_d    = 1'b0;
          cnt_d    = '0;
          is_div_d = op[1];
          neg_d    = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d   = sgn_op & a[WIDTH-1];
          mt_lo_d  = op[0];
          if (op[2]) begin
            state_d = S_MT;
            prod_d  = {{WIDTH{1'b0}}, a};
          end else if (op[1] && (b == '0)) begin
            state_d = S_DZ;
            prod_d  = {{WIDTH{1'b0}}, a};
          end else if (op[1]) begin
            state_d = S_DIV;
            prod_d  = {{WIDTH{1'b0}}, a_mag};
            mcand_d = b_mag;
          end else begin
            state_d = S_MUL;
            prod_d  = {{WIDTH{1'b0}}, b_mag};
            mcand_d = a_mag;
          end
        end
      end

      S_MUL: begin
        // Add multiplicand into the upper half when the current multiplier
        // bit is set, then shift the whole product right by one.
        if (prod_q[0]) begin
          prod_d = {add_sum, prod_q[WIDTH-1:1]};
        end else begin
          prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end

      S_DIV: begin
        // Restoring step: trial-subtract the divisor from the remainder
        // shifted left with the next dividend bit; keep it if non-negative.
        if (!div_diff[WIDTH]) begin
          prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
          prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else if (neg_q) begin
          {hi_d, lo_d} = prod_neg;
        end else begin
          {hi_d, lo_d} = prod_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_DZ: begin
        hi_d    = prod_q[WIDTH-1:0];
        lo_d    = '1;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_MT: begin
        if (mt_lo_q) begin
          lo_d = prod_q[WIDTH-1:0];
        end else begin
          hi_d = prod_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mt_lo_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      mt_lo_q  <= mt_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) ||
                       (state_q == S_FIX) || (state_q == S_DZ);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
